// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Add/sub/logic/pass finish in the accepting cycle;
// shifts and rotates step one bit position per clock. Result and flags are
// registered and only change on completion.
module alu_mc #(
    parameter int unsigned  W  = 8,
    localparam int unsigned CW = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   alu_cmd,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    input  logic         sc_i,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] rslt,
    output logic         sc_o,
    output logic         pari,
    output logic         zero
);

    localparam int unsigned   LW    = $clog2(W);
    localparam logic [W:0]    W_EXT = (W + 1)'(W);
    localparam logic [CW-1:0] N_MAX = CW'(W);
    localparam logic [CW-1:0] N_ONE = CW'(1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    typedef enum logic [2:0] {
        CMD_ADD  = 3'b000,
        CMD_SUB  = 3'b001,
        CMD_SHR  = 3'b010,
        CMD_SHL  = 3'b011,
        CMD_XOR  = 3'b100,
        CMD_ROL  = 3'b101,
        CMD_AND  = 3'b110,
        CMD_PASS = 3'b111
    } cmd_e;

    state_e         state_q, state_d;
    cmd_e           cmd_in;
    cmd_e           cmd_q, cmd_d;
    logic [W-1:0]   work_q, work_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           fill_q, fill_d;
    logic [W-1:0]   rslt_q, rslt_d;
    logic           sc_q, sc_d;
    logic           done_q, done_d;

    logic [CW-1:0]  n_start;
    logic [W:0]     sum;
    logic [W-1:0]   imm_rslt;
    logic           imm_c;
    logic [W-1:0]   step_work;
    logic           step_bit;
    logic           accept;
    logic           finish;

    assign cmd_in = cmd_e'(alu_cmd);

    // Iteration count for the incoming command (0 means single-cycle)
    always_comb begin
        n_start = '0;
        case (cmd_in)
            CMD_SHR, CMD_SHL: begin
                if ({1'b0, inB} >= W_EXT) begin
                    n_start = N_MAX;
                end else begin
                    n_start = CW'(inB);
                end
            end
            CMD_ROL: n_start = CW'(inB[LW-1:0]);
            default: n_start = '0;
        endcase
    end

    // Single-cycle result; shifts/rotates with zero count pass inA through
    always_comb begin
        sum      = '0;
        imm_rslt = inA;
        imm_c    = 1'b0;
        case (cmd_in)
            CMD_ADD: begin
                sum      = {1'b0, inA} + {1'b0, inB} + {{W{1'b0}}, sc_i};
                imm_rslt = sum[W-1:0];
                imm_c    = sum[W];
            end
            CMD_SUB: begin
                sum      = {1'b0, inA} + {1'b0, ~inB} + {{W{1'b0}}, sc_i};
                imm_rslt = sum[W-1:0];
                imm_c    = sum[W];
            end
            CMD_XOR:  imm_rslt = inA ^ inB;
            CMD_AND:  imm_rslt = inA & inB;
            CMD_PASS: imm_rslt = inA;
            default:  imm_rslt = inA;
        endcase
    end

    // One shift/rotate step on the working register and the bit it ejects
    always_comb begin
        step_work = work_q;
        step_bit  = 1'b0;
        case (cmd_q)
            CMD_SHR: begin
                step_work = {fill_q, work_q[W-1:1]};
                step_bit  = work_q[0];
            end
            CMD_SHL: begin
                step_work = {work_q[W-2:0], fill_q};
                step_bit  = work_q[W-1];
            end
            CMD_ROL: begin
                step_work = {work_q[W-2:0], work_q[W-1]};
                step_bit  = work_q[W-1];
            end
            default: begin
                step_work = work_q;
                step_bit  = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && (n_start != '0)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == N_ONE) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy flag and the accept/finish strobes for the datapath
    always_comb begin
        busy   = 1'b0;
        accept = 1'b0;
        finish = 1'b0;
        case (state_q)
            S_IDLE: accept = start;
            S_RUN: begin
                busy   = 1'b1;
                finish = (cnt_q == N_ONE);
            end
            default: begin
                busy   = 1'b0;
                accept = 1'b0;
                finish = 1'b0;
            end
        endcase
    end

    // Datapath next-state: capture on accept, step while running, publish on completion.
    // The final step's value goes straight to rslt so the result lands on the
    // same edge the counter reaches zero.
    always_comb begin
        cmd_d  = cmd_q;
        work_d = work_q;
        cnt_d  = cnt_q;
        fill_d = fill_q;
        rslt_d = rslt_q;
        sc_d   = sc_q;
        done_d = 1'b0;
        if (accept) begin
            if (n_start == '0) begin
                rslt_d = imm_rslt;
                sc_d   = imm_c;
                done_d = 1'b1;
            end else begin
                cmd_d  = cmd_in;
                work_d = inA;
                cnt_d  = n_start;
                fill_d = sc_i;
            end
        end
        if (busy) begin
            work_d = step_work;
            cnt_d  = cnt_q - N_ONE;
            if (finish) begin
                rslt_d = step_work;
                sc_d   = step_bit;
                done_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q  <= CMD_ADD;
            work_q <= '0;
            cnt_q  <= '0;
            fill_q <= 1'b0;
            rslt_q <= '0;
            sc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cmd_q  <= cmd_d;
            work_q <= work_d;
            cnt_q  <= cnt_d;
            fill_q <= fill_d;
            rslt_q <= rslt_d;
            sc_q   <= sc_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign rslt = rslt_q;
    assign sc_o = sc_q;
    assign pari = ^rslt_q;
    assign zero = (rslt_q == '0);

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: the driver pushes expected results computed by
// an arithmetic reference model, a negedge monitor pops them on every done.
module tb_alu_mc;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   alu_cmd = 3'd0;
    logic [W-1:0] inA = '0;
    logic [W-1:0] inB = '0;
    logic         sc_i = 1'b0;
    logic         busy, done, sc_o, pari, zero;
    logic [W-1:0] rslt;

    alu_mc #(.W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .alu_cmd (alu_cmd),
        .inA     (inA),
        .inB     (inB),
        .sc_i    (sc_i),
        .busy    (busy),
        .done    (done),
        .rslt    (rslt),
        .sc_o    (sc_o),
        .pari    (pari),
        .zero    (zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int r;
        int c;
        int due;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   held_r = 0;
    int   held_c = 0;
    int   busy_lo = 0;
    int   busy_hi = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, expv, $time);
        end
    endtask

    // Reference behaviour from the command table, plain integer arithmetic
    function automatic void model(input int cmd, input int a, input int b, input int s,
                                  output int r, output int c, output int n);
        int sum;
        r = a;
        c = 0;
        n = 0;
        case (cmd)
            0: begin sum = a + b + s; r = sum & MASK; c = (sum >> W) & 1; end
            1: begin sum = a + ((~b) & MASK) + s; r = sum & MASK; c = (sum >> W) & 1; end
            2: begin
                n = (b < W) ? b : W;
                if (n > 0) begin
                    r = (a >> n) | (s != 0 ? (MASK & ~(MASK >> n)) : 0);
                    c = (a >> (n - 1)) & 1;
                end
            end
            3: begin
                n = (b < W) ? b : W;
                if (n > 0) begin
                    r = ((a << n) | (s != 0 ? ((1 << n) - 1) : 0)) & MASK;
                    c = (a >> (W - n)) & 1;
                end
            end
            4: r = a ^ b;
            5: begin
                n = b % W;
                if (n > 0) begin
                    r = ((a << n) | (a >> (W - n))) & MASK;
                    c = (a >> (W - n)) & 1;
                end
            end
            6: r = a & b;
            default: r = a;
        endcase
    endfunction

    // Present one request; start stays high until the caller drops it
    task automatic drive(input int cmd, input int a, input int b, input int s);
        int r, c, n;
        exp_t x;
        @(negedge clk);
        start   = 1'b1;
        alu_cmd = cmd[2:0];
        inA     = a[W-1:0];
        inB     = b[W-1:0];
        sc_i    = s[0];
        @(posedge clk);
        #1;
        model(cmd, a & MASK, b & MASK, s & 1, r, c, n);
        x.r   = r;
        x.c   = c;
        x.due = cyc + n;
        exp_q.push_back(x);
        busy_lo = cyc;
        busy_hi = cyc + n;
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("drain_pending", exp_q.size(), 0);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    // Monitor: busy window, hold behaviour, and completion results
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            held_r = 0;
            held_c = 0;
        end else begin
            chk("busy", busy, (cyc >= busy_lo && cyc < busy_hi) ? 1 : 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rslt", rslt, e.r);
                    chk("sc_o", sc_o, e.c);
                    chk("pari", pari, $countones(e.r) & 1);
                    chk("zero", zero, (e.r == 0) ? 1 : 0);
                    chk("done_cycle", cyc, e.due);
                    held_r = e.r;
                    held_c = e.c;
                end
            end else begin
                chk("hold_rslt", rslt, held_r);
                chk("hold_sc", sc_o, held_c);
            end
        end
    end

    initial begin
        int cmd, a, b, s;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;

        repeat (4) begin
            @(negedge clk);
            chk("reset_rslt", rslt, 0);
            chk("reset_zero", zero, 1);
            chk("reset_pari", pari, 0);
            chk("reset_done", done, 0);
            chk("reset_busy", busy, 0);
        end

        // ADD then SUB accepted in the done cycle
        drive(0, 200, 100, 1);
        drive(1, 3, 5, 1);
        release_start();
        wait_idle(4);

        // SHL by 3
        drive(3, 'h81, 3, 0);
        release_start();
        wait_idle(10);

        // SHR clipped to W steps, with an ignored start while busy
        drive(2, 'hF0, 12, 1);
        release_start();
        @(negedge clk);
        start   = 1'b1;
        alu_cmd = 3'd0;
        inA     = 8'h11;
        inB     = 8'h22;
        @(negedge clk);
        start = 1'b0;
        wait_idle(16);

        // ROL by 9 (one step) and SHL by zero
        drive(5, 'h81, 9, 0);
        release_start();
        wait_idle(6);
        drive(3, 'h5A, 0, 1);
        release_start();
        wait_idle(4);

        // Reset in the middle of a run
        drive(2, 'hAA, 6, 0);
        release_start();
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rslt", rslt, 0);
        chk("abort_sc", sc_o, 0);
        chk("abort_zero", zero, 1);
        chk("abort_pari", pari, 0);
        busy_lo = 0;
        busy_hi = 0;
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (10) @(negedge clk);
        drive(2, 'hAA, 6, 0);
        release_start();
        wait_idle(10);

        // Back-to-back single-cycle operations with start held high
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 4))
                0: cmd = 0;
                1: cmd = 1;
                2: cmd = 4;
                3: cmd = 6;
                default: cmd = 7;
            endcase
            drive(cmd, $urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, 1));
        end
        release_start();
        wait_idle(4);

        // Random mix of all commands
        for (int i = 0; i < 80; i++) begin
            cmd = $urandom_range(0, 7);
            a   = $urandom_range(0, MASK);
            b   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : $urandom_range(0, MASK);
            s   = $urandom_range(0, 1);
            drive(cmd, a, b, s);
            release_start();
            wait_idle(W + 4);
        end

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, width-parametrised successor to the processor's single-cycle ALU. It accepts one operation per start pulse and executes add, subtract, logic and pass in one cycle. Shifts and rotates by a variable amount run iteratively, one bit position per clock. Result, carry, parity and zero are registered and held until the next completion, so the control unit can read them at its convenience.

## Interface
- `W`, 8: data path width in bits. Power of two, at least 4.
- `CW`, `$clog2(W)+1`: width of the internal iteration counter. Derived; not overridden.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request. Sampled only in IDLE.
- `alu_cmd` in 3: operation select, captured with `start`.
- `inA` in W: operand A, captured with `start`.
- `inB` in W: operand B or shift/rotate amount, captured with `start`.
- `sc_i` in 1: carry-in, or fill bit for shifts. Captured with `start`.
- `busy` out 1: iteration in progress.
- `done` out 1: one-cycle completion pulse.
- `rslt` out W: registered result.
- `sc_o` out 1: registered carry-out or last bit shifted out.
- `pari` out 1: reduction XOR of `rslt`. Combinational from the `rslt` register.
- `zero` out 1: `rslt == 0`. Combinational from the `rslt` register.

## Operation
- Commands. N is the iteration count.
  - 000 ADD: `{sc_o,rslt} = inA + inB + sc_i`. N=0.
  - 001 SUB: `{sc_o,rslt} = inA + ~inB + sc_i`. `sc_i`=1 means no borrow in; `sc_o`=1 means no borrow out. N=0.
  - 010 SHR: logical right shift, `sc_i` shifted into the MSB each step, `sc_o` = last bit shifted out of the LSB. N = min(inB, W).
  - 011 SHL: left shift, `sc_i` shifted into the LSB each step, `sc_o` = last bit shifted out of the MSB. N = min(inB, W).
  - 100 XOR: `rslt = inA ^ inB`, `sc_o`=0. N=0.
  - 101 ROL: rotate left, one position per step, `sc_o` = bit landing in the LSB on the final step. N = inB mod W.
  - 110 AND: `rslt = inA & inB`, `sc_o`=0. N=0.
  - 111 PASS: `rslt = inA`, `sc_o`=0. N=0.
- For shifts and rotates with N=0: `rslt = inA`, `sc_o`=0.
- Arithmetic is unsigned, modulo 2^W. The carry is bit W of the (W+1)-bit sum.
- State machine: IDLE, RUN.
  - IDLE & `start` & N=0: compute, load `rslt`/`sc_o`, pulse `done`, stay in IDLE.
  - IDLE & `start` & N>0: load the working register with `inA`, load the counter with N, go to RUN.
  - RUN: perform one step per edge and decrement the counter. On the edge where the counter reaches 0, load `rslt`/`sc_o` from the working register, pulse `done`, and go to IDLE.
- Intermediate steps never update `rslt` or `sc_o`. Outputs change only on completion.
- `start` in RUN is ignored. No queueing.
- `start` in the cycle `done` is high is accepted (the FSM is in IDLE).

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `rslt`=0, `sc_o`=0, hence `pari`=0, `zero`=1. The working register and counter are cleared.
- Latency from the `start` sampling edge k: `done` is high in the cycle after edge k+N, i.e. N+1 cycles.
- `busy` is high in the cycles following edges k .. k+N-1 (N cycles). It is low in the `done` cycle and never high when N=0.
- `done` is high for exactly one cycle per accepted start.
- Throughput: one N=0 operation per cycle with `start` held high.
- Reset asserted mid-RUN: abort immediately to reset values. No `done` pulse. The operation is lost.
- Input operands may change freely after the sampling edge.

## Test plan
- Reset release, no start: `rslt`=0x00, `zero`=1, `pari`=0, `busy`=0, `done`=0 indefinitely.
- ADD, W=8, inA=200, inB=100, sc_i=1: after 1 cycle `done`=1, `rslt`=0x2D, `sc_o`=1, `pari`=0, `zero`=0. Then start asserted in the `done` cycle for SUB inA=3, inB=5, sc_i=1: next cycle `rslt`=0xFE, `sc_o`=0.
- SHL inA=0x81, inB=3, sc_i=0: `busy` high 3 cycles, `done` 4 cycles after start, `rslt`=0x08, `sc_o`=0. `rslt` holds its prior value during `busy`.
- SHR inA=0xF0, inB=12, sc_i=1: clipped to 8 steps, `done` after 9 cycles, `rslt`=0xFF, `sc_o`=1. A start pulse with new operands during `busy` is ignored and produces no extra `done`.
- ROL inA=0x81, inB=9: N=1, `done` after 2 cycles, `rslt`=0x03, `sc_o`=1. SHL with inB=0 gives `rslt`=inA, `sc_o`=0, `done` after 1 cycle.
- SHR inA=0xAA, inB=6, then `reset` pulsed at cycle 3: all outputs return to reset values asynchronously, no `done` appears, and the next start executes normally.
